// File: rtl/io_gate_if.sv
// Signal bundle for io_gate. It covers the CPU bus, the permission-bitmap check port and the I/O bus.
// slave is the io_gate view of the bundle; master is the view of whatever drives io_gate.
interface io_gate_if #(
    parameter int ASID_W = 6,
    parameter int ADR_W  = 20
);
    logic              cs_i;
    logic              cyc_i;
    logic              stb_i;
    logic              we_i;
    logic [3:0]        sel_i;
    logic              priv_i;
    logic [ASID_W-1:0] asid_i;
    logic [ADR_W-1:0]  adr_i;
    logic [31:0]       dat_i;
    logic              ack_o;
    logic              err_o;
    logic [31:0]       dat_o;
    logic              bm_cs_o;
    logic              bm_cyc_o;
    logic              bm_stb_o;
    logic [ASID_W-1:0] bm_asid_o;
    logic [ADR_W-1:0]  bm_adr_o;
    logic              bm_gate_i;
    logic              bm_gate_en_i;
    logic              io_cyc_o;
    logic              io_stb_o;
    logic              io_we_o;
    logic [3:0]        io_sel_o;
    logic [ADR_W-1:0]  io_adr_o;
    logic [31:0]       io_dat_o;
    logic [31:0]       io_dat_i;
    logic              io_ack_i;
    logic              fault_o;
    logic [ADR_W-1:0]  fault_adr_o;
    logic [ASID_W-1:0] fault_asid_o;

    modport slave (
        input  cs_i, cyc_i, stb_i, we_i, sel_i, priv_i, asid_i, adr_i, dat_i,
               bm_gate_i, bm_gate_en_i, io_dat_i, io_ack_i,
        output ack_o, err_o, dat_o, bm_cs_o, bm_cyc_o, bm_stb_o, bm_asid_o, bm_adr_o,
               io_cyc_o, io_stb_o, io_we_o, io_sel_o, io_adr_o, io_dat_o,
               fault_o, fault_adr_o, fault_asid_o
    );

    modport master (
        output cs_i, cyc_i, stb_i, we_i, sel_i, priv_i, asid_i, adr_i, dat_i,
               bm_gate_i, bm_gate_en_i, io_dat_i, io_ack_i,
        input  ack_o, err_o, dat_o, bm_cs_o, bm_cyc_o, bm_stb_o, bm_asid_o, bm_adr_o,
               io_cyc_o, io_stb_o, io_we_o, io_sel_o, io_adr_o, io_dat_o,
               fault_o, fault_adr_o, fault_asid_o
    );
endinterface

// File: rtl/io_gate.sv
// Gatekeeper for CPU I/O cycles. Privileged cycles go straight to the I/O bus; all others are
// first checked against the permission bitmap. Define IO_GATE_TIMEOUT_EN to enable the optional watchdog.
module io_gate #(
    parameter int ASID_W     = 6,
    parameter int ADR_W      = 20,
    parameter int TMO_CYCLES = 255
) (
    input  logic     clk_i,
    input  logic     rst_i,
    io_gate_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_FWD,
        ST_RESP,
        ST_DENY,
        ST_WAITEND
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_we;
    logic [3:0]        r_sel;
    logic [ASID_W-1:0] r_asid;
    logic [ADR_W-1:0]  r_adr;
    logic [31:0]       r_dat;
    logic [31:0]       r_rdat;
    logic [ADR_W-1:0]  r_fault_adr;
    logic [ASID_W-1:0] r_fault_asid;
    logic              w_req;
    logic              w_tmo;
    logic              w_bm_stb;
    logic              w_io_stb;
    logic              w_ack;
    logic              w_err;

    assign w_req = bus.cs_i & bus.cyc_i & bus.stb_i;

`ifdef IO_GATE_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TMO_CYCLES + 1) > 8) ? $clog2(TMO_CYCLES + 1) : 8;
    logic [CNT_W-1:0] r_tmo_cnt;

    // Any state change restarts the count, so the FWD leg of a gated access gets its own full budget.
    always_ff @(posedge clk_i) begin
        if (rst_i || (w_state_nxt != r_state)) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == ST_LOOKUP) || (r_state == ST_FWD)) begin
            r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
        end
    end

    assign w_tmo = (r_tmo_cnt == CNT_W'(TMO_CYCLES - 1));
`else
    assign w_tmo = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case, so no path can infer a latch.
        w_state_nxt = r_state;
        w_bm_stb    = 1'b0;
        w_io_stb    = 1'b0;
        w_ack       = 1'b0;
        w_err       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_req) w_state_nxt = bus.priv_i ? ST_FWD : ST_LOOKUP;
            end
            ST_LOOKUP: begin
                w_bm_stb = 1'b1;
                if (!bus.cyc_i)             w_state_nxt = ST_IDLE;
                else if (bus.bm_gate_en_i)  w_state_nxt = bus.bm_gate_i ? ST_FWD : ST_DENY;
                else if (w_tmo)             w_state_nxt = ST_DENY;
            end
            ST_FWD: begin
                w_io_stb = 1'b1;
                if (!bus.cyc_i)         w_state_nxt = ST_IDLE;
                else if (bus.io_ack_i)  w_state_nxt = ST_RESP;
                else if (w_tmo)         w_state_nxt = ST_DENY;
            end
            ST_RESP: begin
                w_ack       = 1'b1;
                w_state_nxt = ST_WAITEND;
            end
            ST_DENY: begin
                w_err       = 1'b1;
                w_state_nxt = ST_WAITEND;
            end
            ST_WAITEND: begin
                if (!bus.stb_i) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_we         <= 1'b0;
            r_sel        <= '0;
            r_asid       <= '0;
            r_adr        <= '0;
            r_dat        <= '0;
            r_rdat       <= '0;
            r_fault_adr  <= '0;
            r_fault_asid <= '0;
        end else begin
            // NOTE: sequential state uses <= so every register samples pre-edge values together.
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && w_req) begin
                r_we   <= bus.we_i;
                r_sel  <= bus.sel_i;
                r_asid <= bus.asid_i;
                r_adr  <= bus.adr_i;
                r_dat  <= bus.dat_i;
            end
            if ((r_state == ST_FWD) && (w_state_nxt == ST_RESP)) begin
                r_rdat <= r_we ? 32'h0 : bus.io_dat_i;
            end
            if (w_state_nxt == ST_DENY) begin
                r_rdat       <= 32'h0;
                r_fault_adr  <= r_adr;
                r_fault_asid <= r_asid;
            end
        end
    end

    assign bus.ack_o        = w_ack;
    assign bus.err_o        = w_err;
    assign bus.fault_o      = w_err;
    assign bus.dat_o        = r_rdat;
    assign bus.bm_cs_o      = w_bm_stb;
    assign bus.bm_cyc_o     = w_bm_stb;
    assign bus.bm_stb_o     = w_bm_stb;
    assign bus.bm_asid_o    = w_bm_stb ? r_asid : '0;
    assign bus.bm_adr_o     = w_bm_stb ? r_adr : '0;
    assign bus.io_cyc_o     = w_io_stb;
    assign bus.io_stb_o     = w_io_stb;
    assign bus.io_we_o      = w_io_stb & r_we;
    assign bus.io_sel_o     = w_io_stb ? r_sel : 4'h0;
    assign bus.io_adr_o     = w_io_stb ? r_adr : '0;
    assign bus.io_dat_o     = w_io_stb ? r_dat : 32'h0;
    assign bus.fault_adr_o  = r_fault_adr;
    assign bus.fault_asid_o = r_fault_asid;
endmodule

// File: tb/tb_io_gate.sv
// Directed bench for io_gate. The DUT is built with TMO_CYCLES = 16; with IO_GATE_TIMEOUT_EN
// defined the watchdog path is exercised, otherwise FWD is expected to wait indefinitely.
module tb_io_gate;
    localparam int ASID_W = 6;
    localparam int ADR_W  = 20;
    localparam int TMO    = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    io_gate_if #(.ASID_W(ASID_W), .ADR_W(ADR_W)) bus ();

    io_gate #(.ASID_W(ASID_W), .ADR_W(ADR_W), .TMO_CYCLES(TMO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_idle();
        bus.cs_i   = 1'b0;
        bus.cyc_i  = 1'b0;
        bus.stb_i  = 1'b0;
        bus.we_i   = 1'b0;
        bus.sel_i  = 4'h0;
        bus.priv_i = 1'b0;
        bus.asid_i = '0;
        bus.adr_i  = '0;
        bus.dat_i  = 32'h0;
    endtask

    task automatic env_idle();
        bus.bm_gate_i    = 1'b0;
        bus.bm_gate_en_i = 1'b0;
        bus.io_ack_i     = 1'b0;
        bus.io_dat_i     = 32'h0;
    endtask

    task automatic cpu_req(input logic priv, input logic we, input logic [ASID_W-1:0] asid,
                           input logic [ADR_W-1:0] adr, input logic [31:0] dat);
        bus.cs_i   = 1'b1;
        bus.cyc_i  = 1'b1;
        bus.stb_i  = 1'b1;
        bus.we_i   = we;
        bus.sel_i  = 4'hF;
        bus.priv_i = priv;
        bus.asid_i = asid;
        bus.adr_i  = adr;
        bus.dat_i  = dat;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cpu_req(1'b0, 1'b1, 6'h3F, 20'hFFFFF, 32'hFFFFFFFF);
        bus.io_ack_i = 1'b1;
        bus.bm_gate_en_i = 1'b1;
        tick();
        tick();
        n_total++;
        if ({bus.ack_o, bus.err_o, bus.fault_o, bus.bm_stb_o, bus.io_stb_o} !== 5'b0)
            $display("FAIL reset_strobes: got %b want 00000", {bus.ack_o, bus.err_o, bus.fault_o, bus.bm_stb_o, bus.io_stb_o});
        else n_pass++;
        n_total++;
        if ({bus.dat_o, bus.fault_adr_o, bus.fault_asid_o} !== '0)
            $display("FAIL reset_regs: got dat %h fadr %h fasid %h want 0", bus.dat_o, bus.fault_adr_o, bus.fault_asid_o);
        else n_pass++;
        cpu_idle();
        env_idle();
        rst = 1'b0;
        tick();
        n_total++;
        if ({bus.bm_cs_o, bus.bm_cyc_o, bus.io_cyc_o, bus.bm_adr_o, bus.io_adr_o} !== '0)
            $display("FAIL reset_release: got bm_cs %b bm_cyc %b io_cyc %b bm_adr %h io_adr %h want 0",
                     bus.bm_cs_o, bus.bm_cyc_o, bus.io_cyc_o, bus.bm_adr_o, bus.io_adr_o);
        else n_pass++;
    endtask

    task automatic test_priv_read();
        cpu_req(1'b1, 1'b0, 6'h01, 20'h00120, 32'h0);
        tick();
        n_total++;
        if ({bus.io_stb_o, bus.io_cyc_o, bus.bm_stb_o, bus.io_we_o} !== 4'b1100)
            $display("FAIL priv_strobes: got io_stb %b io_cyc %b bm_stb %b io_we %b want 1 1 0 0",
                     bus.io_stb_o, bus.io_cyc_o, bus.bm_stb_o, bus.io_we_o);
        else n_pass++;
        n_total++;
        if (bus.io_adr_o !== 20'h00120) $display("FAIL priv_adr: got %h want 00120", bus.io_adr_o);
        else n_pass++;
        bus.io_ack_i = 1'b1;
        bus.io_dat_i = 32'hDEADBEEF;
        tick();
        n_total++;
        if ({bus.ack_o, bus.err_o, bus.io_stb_o} !== 3'b100)
            $display("FAIL priv_ack: got ack %b err %b io_stb %b want 1 0 0", bus.ack_o, bus.err_o, bus.io_stb_o);
        else n_pass++;
        n_total++;
        if (bus.dat_o !== 32'hDEADBEEF) $display("FAIL priv_rdata: got %h want deadbeef", bus.dat_o);
        else n_pass++;
        env_idle();
        cpu_idle();
        tick();
        n_total++;
        if ({bus.ack_o, bus.dat_o} !== {1'b0, 32'hDEADBEEF})
            $display("FAIL priv_hold: got ack %b dat %h want 0 deadbeef", bus.ack_o, bus.dat_o);
        else n_pass++;
        tick();
    endtask

    task automatic test_deny_read();
        int io_seen = 0;
        cpu_req(1'b0, 1'b0, 6'h2A, 20'hABCDE, 32'h0);
        tick();
        n_total++;
        if ({bus.bm_cs_o, bus.bm_stb_o, bus.bm_adr_o, bus.bm_asid_o} !== {2'b11, 20'hABCDE, 6'h2A})
            $display("FAIL deny_lookup: got cs %b stb %b adr %h asid %h want 1 1 abcde 2a",
                     bus.bm_cs_o, bus.bm_stb_o, bus.bm_adr_o, bus.bm_asid_o);
        else n_pass++;
        io_seen += int'(bus.io_stb_o);
        bus.bm_gate_en_i = 1'b1;
        bus.bm_gate_i = 1'b0;
        tick();
        io_seen += int'(bus.io_stb_o);
        n_total++;
        if ({bus.err_o, bus.fault_o, bus.ack_o, bus.bm_stb_o} !== 4'b1100)
            $display("FAIL deny_err: got err %b fault %b ack %b bm_stb %b want 1 1 0 0",
                     bus.err_o, bus.fault_o, bus.ack_o, bus.bm_stb_o);
        else n_pass++;
        n_total++;
        if (bus.dat_o !== 32'h0) $display("FAIL deny_dat: got %h want 0", bus.dat_o);
        else n_pass++;
        n_total++;
        if ({bus.fault_adr_o, bus.fault_asid_o} !== {20'hABCDE, 6'h2A})
            $display("FAIL deny_fault_regs: got %h/%h want abcde/2a", bus.fault_adr_o, bus.fault_asid_o);
        else n_pass++;
        env_idle();
        cpu_idle();
        tick();
        io_seen += int'(bus.io_stb_o);
        n_total++;
        if ({bus.err_o, bus.fault_o, bus.fault_adr_o} !== {2'b00, 20'hABCDE})
            $display("FAIL deny_pulse: got err %b fault %b fadr %h want 0 0 abcde", bus.err_o, bus.fault_o, bus.fault_adr_o);
        else n_pass++;
        n_total++;
        if (io_seen !== 0) $display("FAIL deny_no_io: got %0d io_stb cycles want 0", io_seen);
        else n_pass++;
        tick();
    endtask

    task automatic test_gated_write();
        int acks = 0;
        cpu_req(1'b0, 1'b1, 6'd5, 20'h12345, 32'hA5A5A5A5);
        tick();
        bus.adr_i = 20'h0;
        bus.dat_i = 32'h0;
        bus.asid_i = 6'h0;
        for (int c = 1; c <= 3; c++) begin
            n_total++;
            if ({bus.bm_stb_o, bus.bm_adr_o, bus.bm_asid_o, bus.io_stb_o} !== {1'b1, 20'h12345, 6'd5, 1'b0})
                $display("FAIL gw_lookup_c%0d: got stb %b adr %h asid %h io_stb %b want 1 12345 05 0",
                         c, bus.bm_stb_o, bus.bm_adr_o, bus.bm_asid_o, bus.io_stb_o);
            else n_pass++;
            bus.bm_gate_i    = (c >= 2);
            bus.bm_gate_en_i = (c == 3);
            if (c < 3) tick();
        end
        tick();
        env_idle();
        for (int c = 4; c <= 5; c++) begin
            n_total++;
            if ({bus.bm_stb_o, bus.io_stb_o, bus.io_we_o, bus.io_sel_o, bus.io_adr_o, bus.io_dat_o} !==
                {3'b011, 4'hF, 20'h12345, 32'hA5A5A5A5})
                $display("FAIL gw_fwd_c%0d: got bm_stb %b io_stb %b we %b sel %h adr %h dat %h want 0 1 1 f 12345 a5a5a5a5",
                         c, bus.bm_stb_o, bus.io_stb_o, bus.io_we_o, bus.io_sel_o, bus.io_adr_o, bus.io_dat_o);
            else n_pass++;
            if (c == 4) tick();
        end
        bus.io_ack_i = 1'b1;
        bus.io_dat_i = 32'h11111111;
        tick();
        n_total++;
        if ({bus.ack_o, bus.dat_o} !== {1'b1, 32'h0})
            $display("FAIL gw_ack: got ack %b dat %h want 1 0", bus.ack_o, bus.dat_o);
        else n_pass++;
        env_idle();
        cpu_idle();
        for (int c = 0; c < 3; c++) begin
            tick();
            acks += int'(bus.ack_o);
        end
        n_total++;
        if (acks !== 0) $display("FAIL gw_single_ack: got %0d extra acks want 0", acks);
        else n_pass++;
    endtask

    task automatic test_hold_stb();
        int extra = 0;
        cpu_req(1'b1, 1'b1, 6'h00, 20'h00777, 32'h0BADF00D);
        tick();
        bus.io_ack_i = 1'b1;
        tick();
        n_total++;
        if (bus.ack_o !== 1'b1) $display("FAIL hold_ack: got %b want 1", bus.ack_o);
        else n_pass++;
        env_idle();
        for (int c = 0; c < 5; c++) begin
            tick();
            extra += int'(bus.ack_o) + int'(bus.err_o) + int'(bus.bm_stb_o) + int'(bus.io_stb_o);
        end
        n_total++;
        if (extra !== 0) $display("FAIL hold_no_reissue: got %0d events want 0", extra);
        else n_pass++;
        cpu_idle();
        tick();
        cpu_req(1'b1, 1'b0, 6'h00, 20'h00888, 32'h0);
        tick();
        n_total++;
        if ({bus.io_stb_o, bus.io_adr_o} !== {1'b1, 20'h00888})
            $display("FAIL hold_next_req: got io_stb %b adr %h want 1 00888", bus.io_stb_o, bus.io_adr_o);
        else n_pass++;
        bus.io_ack_i = 1'b1;
        bus.io_dat_i = 32'h13572468;
        tick();
        n_total++;
        if ({bus.ack_o, bus.dat_o} !== {1'b1, 32'h13572468})
            $display("FAIL hold_next_ack: got ack %b dat %h want 1 13572468", bus.ack_o, bus.dat_o);
        else n_pass++;
        env_idle();
        cpu_idle();
        tick();
        tick();
    endtask

    task automatic test_abort();
        cpu_req(1'b1, 1'b0, 6'h00, 20'h00ABC, 32'h0);
        tick();
        n_total++;
        if (bus.io_stb_o !== 1'b1) $display("FAIL abort_fwd_stb: got %b want 1", bus.io_stb_o);
        else n_pass++;
        cpu_idle();
        tick();
        n_total++;
        if ({bus.io_stb_o, bus.io_cyc_o, bus.ack_o, bus.err_o} !== 4'b0)
            $display("FAIL abort_fwd_drop: got io_stb %b io_cyc %b ack %b err %b want 0", bus.io_stb_o, bus.io_cyc_o, bus.ack_o, bus.err_o);
        else n_pass++;
        bus.io_ack_i = 1'b1;
        bus.io_dat_i = 32'hFFFFFFFF;
        bus.bm_gate_en_i = 1'b1;
        tick();
        n_total++;
        if ({bus.ack_o, bus.err_o, bus.fault_o, bus.bm_stb_o, bus.io_stb_o} !== 5'b0)
            $display("FAIL abort_late_ack: got %b want 00000", {bus.ack_o, bus.err_o, bus.fault_o, bus.bm_stb_o, bus.io_stb_o});
        else n_pass++;
        n_total++;
        if ({bus.dat_o, bus.fault_adr_o, bus.fault_asid_o} !== {32'h13572468, 20'hABCDE, 6'h2A})
            $display("FAIL abort_regs: got dat %h fadr %h fasid %h want 13572468 abcde 2a", bus.dat_o, bus.fault_adr_o, bus.fault_asid_o);
        else n_pass++;
        env_idle();
        cpu_req(1'b0, 1'b0, 6'h07, 20'h00055, 32'h0);
        tick();
        cpu_idle();
        tick();
        n_total++;
        if ({bus.bm_stb_o, bus.err_o, bus.fault_o} !== 3'b000)
            $display("FAIL abort_lookup: got bm_stb %b err %b fault %b want 0 0 0", bus.bm_stb_o, bus.err_o, bus.fault_o);
        else n_pass++;
        tick();
        cpu_req(1'b1, 1'b0, 6'h00, 20'h00200, 32'h0);
        tick();
        bus.io_ack_i = 1'b1;
        bus.io_dat_i = 32'h24681357;
        tick();
        n_total++;
        if ({bus.ack_o, bus.dat_o} !== {1'b1, 32'h24681357})
            $display("FAIL abort_recover: got ack %b dat %h want 1 24681357", bus.ack_o, bus.dat_o);
        else n_pass++;
        env_idle();
        cpu_idle();
        tick();
        tick();
    endtask

    task automatic test_timeout();
        int errs = 0;
        int stbs = 0;
        cpu_req(1'b1, 1'b0, 6'h00, 20'h00333, 32'h0);
`ifdef IO_GATE_TIMEOUT_EN
        for (int c = 1; c <= TMO; c++) begin
            tick();
            errs += int'(bus.err_o);
            stbs += int'(bus.io_stb_o);
        end
        n_total++;
        if ({errs, stbs} !== {32'd0, 32'd16})
            $display("FAIL tmo_wait: got errs %0d io_stb cycles %0d want 0 16", errs, stbs);
        else n_pass++;
        tick();
        n_total++;
        if ({bus.err_o, bus.fault_o, bus.io_stb_o, bus.ack_o} !== 4'b1100)
            $display("FAIL tmo_err: got err %b fault %b io_stb %b ack %b want 1 1 0 0", bus.err_o, bus.fault_o, bus.io_stb_o, bus.ack_o);
        else n_pass++;
        n_total++;
        if ({bus.fault_adr_o, bus.fault_asid_o} !== {20'h00333, 6'h00})
            $display("FAIL tmo_fault_regs: got %h/%h want 00333/00", bus.fault_adr_o, bus.fault_asid_o);
        else n_pass++;
        cpu_idle();
        tick();
`else
        for (int c = 1; c <= 40; c++) begin
            tick();
            errs += int'(bus.err_o);
            stbs += int'(bus.io_stb_o);
        end
        n_total++;
        if ({errs, stbs} !== {32'd0, 32'd40})
            $display("FAIL notmo_wait: got errs %0d io_stb cycles %0d want 0 40", errs, stbs);
        else n_pass++;
        cpu_idle();
        tick();
        n_total++;
        if ({bus.io_stb_o, bus.err_o, bus.ack_o} !== 3'b000)
            $display("FAIL notmo_abort: got io_stb %b err %b ack %b want 0 0 0", bus.io_stb_o, bus.err_o, bus.ack_o);
        else n_pass++;
`endif
        tick();
    endtask

    task automatic test_reset_mid();
        cpu_req(1'b0, 1'b0, 6'h11, 20'h54321, 32'h0);
        tick();
        n_total++;
        if (bus.bm_stb_o !== 1'b1) $display("FAIL rstmid_lookup: got %b want 1", bus.bm_stb_o);
        else n_pass++;
        rst = 1'b1;
        tick();
        n_total++;
        if ({bus.bm_stb_o, bus.io_stb_o, bus.ack_o, bus.err_o, bus.fault_o} !== 5'b0)
            $display("FAIL rstmid_drop: got %b want 00000", {bus.bm_stb_o, bus.io_stb_o, bus.ack_o, bus.err_o, bus.fault_o});
        else n_pass++;
        n_total++;
        if ({bus.fault_adr_o, bus.fault_asid_o, bus.dat_o} !== '0)
            $display("FAIL rstmid_regs: got fadr %h fasid %h dat %h want 0", bus.fault_adr_o, bus.fault_asid_o, bus.dat_o);
        else n_pass++;
        rst = 1'b0;
        cpu_idle();
        tick();
    endtask

    initial begin
        cpu_idle();
        env_idle();
        test_reset();
        test_priv_read();
        test_deny_read();
        test_gated_write();
        test_hold_stb();
        test_abort();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
